// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter -- parametrised modulo up/down counter with an enable prescaler.
//
// The counter steps once every DIV enabled cycles. Each step moves up or down
// by one, and wraps at the boundaries: MAX goes to 0 when counting up, and
// 0 goes to MAX when counting down.
//
// Optional feature macro: MOD_COUNTER_SAT_EN
//   defined   : boundary steps saturate (hold at MAX / 0) and wrap stays 0.
//   undefined : wrap-around behaviour.
//
// Parameters
//   WIDTH     count width, 1..32
//   MAX       highest count value (modulus MAX+1), 1..2**WIDTH-1
//   DIV       prescale ratio, >= 1
//   RESET_VAL count value held in reset, <= MAX
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   en        in   count enable
//   load      in   synchronous load strobe (overrides en)
//   load_val  in   load value; values above MAX are clamped to MAX
//   up        in   direction: 1 = up, 0 = down
//   count     out  current count (registered)
//   tc        out  combinational: the next edge performs a boundary step
//   wrap      out  registered one-cycle pulse: count wrapped on the last edge
//
// Handshake: there is none. en/load/up are sampled on every rising edge, and
// count/wrap reflect that sample one cycle later.
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int unsigned     WIDTH     = 3,
    parameter longint unsigned MAX       = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     DIV       = 1,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V   = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_V = RESET_VAL[WIDTH-1:0];

    // High when the prescaler is on its last phase, i.e. an enabled cycle
    // right now would be a step.
    logic pre_last;

    generate
        if (DIV > 1) begin : g_pre
            localparam int unsigned       PRE_W    = $clog2(DIV);
            localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DIV - 1);

            logic [PRE_W-1:0] pre;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pre <= '0;
                end else if (load) begin
                    pre <= '0;
                end else if (en) begin
                    if (pre == PRE_LAST) begin
                        pre <= '0;
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
            end

            assign pre_last = (pre == PRE_LAST);
        end else begin : g_no_pre
            assign pre_last = 1'b1;
        end
    endgenerate

    logic             at_bound;
    logic             step;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    // Boundary test is done before any arithmetic so that WIDTH bits never
    // overflow: at MAX/0 the boundary branch is taken instead of +1/-1.
    assign at_bound = up ? (count == MAX_V) : (count == '0);
    assign step     = en & ~load & pre_last;
    assign tc       = step & at_bound;

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (step) begin
            if (at_bound) begin
`ifdef MOD_COUNTER_SAT_EN
                count_nxt = count;
`else
                count_nxt = up ? '0 : MAX_V;
                wrap_nxt  = 1'b1;
`endif
            end else if (up) begin
                count_nxt = count + 1'b1;
            end else begin
                count_nxt = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RESET_V;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter -- bench for mod_counter.
//
// Three configurations share one set of stimulus inputs:
//   inst 0: WIDTH=3, MAX=7, DIV=1, RESET_VAL=0 (defaults)
//   inst 1: WIDTH=3, MAX=5, DIV=1, RESET_VAL=0
//   inst 2: WIDTH=4, MAX=9, DIV=3, RESET_VAL=2
// A reference model written with modular arithmetic predicts count/wrap/tc.
// -----------------------------------------------------------------------------
module tb_mod_counter;

  localparam int N = 3;
  localparam int P_W[N]   = '{3, 3, 4};
  localparam int P_MAX[N] = '{7, 5, 9};
  localparam int P_DIV[N] = '{1, 1, 3};
  localparam int P_RV[N]  = '{0, 0, 2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic en;
  logic load;
  logic up;
  logic [3:0] load_val;

  always #5 clk = ~clk;

  logic [2:0] count0;
  logic [2:0] count1;
  logic [3:0] count2;
  logic tc0, tc1, tc2;
  logic wrap0, wrap1, wrap2;

  mod_counter #(.WIDTH(3)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val[2:0]),
    .up(up), .count(count0), .tc(tc0), .wrap(wrap0)
  );

  mod_counter #(.WIDTH(3), .MAX(5)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val[2:0]),
    .up(up), .count(count1), .tc(tc1), .wrap(wrap1)
  );

  mod_counter #(.WIDTH(4), .MAX(9), .DIV(3), .RESET_VAL(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .up(up), .count(count2), .tc(tc2), .wrap(wrap2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_count(input int i);
    case (i)
      0: return {29'd0, count0};
      1: return {29'd0, count1};
      default: return {28'd0, count2};
    endcase
  endfunction

  function automatic logic [31:0] dut_wrap(input int i);
    case (i)
      0: return {31'd0, wrap0};
      1: return {31'd0, wrap1};
      default: return {31'd0, wrap2};
    endcase
  endfunction

  function automatic logic [31:0] dut_tc(input int i);
    case (i)
      0: return {31'd0, tc0};
      1: return {31'd0, tc1};
      default: return {31'd0, tc2};
    endcase
  endfunction

  // ---------------- reference model ----------------
  // m_phase counts enabled cycles since the last step/load/reset; a step
  // happens on the enabled cycle where it reaches DIV-1.
  int m_cnt[N];
  int m_phase[N];
  int m_wrap[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]   = P_RV[i];
      m_phase[i] = 0;
      m_wrap[i]  = 0;
    end
  endtask

  function automatic int exp_tc(input int i);
    int hit;
    hit = up ? (m_cnt[i] == P_MAX[i]) : (m_cnt[i] == 0);
    return (en && !load && (m_phase[i] == P_DIV[i] - 1) && hit) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int lv;
    int hit;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      m_wrap[i] = 0;
      if (load) begin
        lv = int'(load_val) % (1 << P_W[i]);
        m_cnt[i]   = (lv > P_MAX[i]) ? P_MAX[i] : lv;
        m_phase[i] = 0;
      end else if (en) begin
        if (m_phase[i] == P_DIV[i] - 1) begin
          m_phase[i] = 0;
          hit = up ? (m_cnt[i] == P_MAX[i]) : (m_cnt[i] == 0);
`ifdef MOD_COUNTER_SAT_EN
          if (!hit) m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
`else
          if (up) m_cnt[i] = (m_cnt[i] + 1) % (P_MAX[i] + 1);
          else    m_cnt[i] = (m_cnt[i] + P_MAX[i]) % (P_MAX[i] + 1);
          m_wrap[i] = hit;
`endif
        end else begin
          m_phase[i]++;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called right after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    for (int i = 0; i < N; i++) check($sformatf("tc%0d", i), dut_tc(i), 32'(exp_tc(i)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("count%0d", i), dut_count(i), 32'(m_cnt[i]));
      check($sformatf("wrap%0d", i),  dut_wrap(i),  32'(m_wrap[i]));
    end
  endtask

  task automatic drive(input logic e, input logic l, input logic u, input logic [3:0] lv);
    en = e; load = l; up = u; load_val = lv;
  endtask

  // Assert reset between edges and confirm it acts without a clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      check($sformatf("async_count%0d", i), dut_count(i), 32'(P_RV[i]));
      check($sformatf("async_wrap%0d", i),  dut_wrap(i),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    model_reset();
    #1;
    for (int i = 0; i < N; i++) check($sformatf("rst_count%0d", i), dut_count(i), 32'(P_RV[i]));
    cycle();
    cycle();
    rst = 1'b0;

    // Up count through the wrap on the default instance.
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    repeat (9) cycle();
    check("seq_up_end0", dut_count(0), 32'd1);
    check("seq_up_end1", dut_count(1), 32'd3);

    // Down count through the MAX=5 wrap.
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (8) cycle();

    // Prescaler: drop en mid-prescale, then resume.
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    repeat (4) cycle();
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    repeat (2) cycle();
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    repeat (5) cycle();

    // Load above MAX clamps; pre cleared so 3 enabled edges give the wrap.
    drive(1'b1, 1'b1, 1'b1, 4'd12);
    cycle();
    check("load_clamp2", dut_count(2), 32'd9);
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    repeat (3) cycle();
`ifndef MOD_COUNTER_SAT_EN
    check("load_wrap_count2", dut_count(2), 32'd0);
    check("load_wrap_pulse2", dut_wrap(2), 32'd1);
`endif

    // Async reset mid-cycle.
    repeat (6) cycle();
    async_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    repeat (4) cycle();

    // Direction change mid-prescale.
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (7) cycle();

    // Randomized stimulus.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset();
      end
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 4) != 0,
            4'($urandom_range(0, 15)));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
